// File: rtl/cd_stack.sv
// cd_stack: parametrised single-cycle datapath with flags, return stack
// Ports: clk/reset, instr in, pc/opcode out, control in, flags/out port/stack status out
module cd_stack #(
  parameter int DW     = 8,
  parameter int PCW    = 10,
  parameter int RAW    = 4,
  parameter int IW     = 18,
  parameter int SDEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [IW-1:0]               instr,
  output logic [PCW-1:0]              pc,
  input  logic                        s_inc,
  input  logic                        s_inm,
  input  logic                        we3,
  input  logic                        wez,
  input  logic [2:0]                  op_alu,
  input  logic                        call,
  input  logic                        ret,
  input  logic                        out_en,
  output logic [5:0]                  opcode,
  output logic                        z,
  output logic                        c,
  output logic [DW-1:0]               out_data,
  output logic [$clog2(SDEPTH+1)-1:0] stk_cnt,
  output logic                        stk_ovf,
  output logic                        stk_unf
);

  localparam int SW = $clog2(SDEPTH+1);
  localparam int NR = 1 << RAW;
  localparam int NS = 1 << SW;

  logic [PCW-1:0] target;
  logic [RAW-1:0] wa;
  logic [RAW-1:0] ra1;
  logic [RAW-1:0] ra2;
  logic [DW-1:0]  imm;

  assign opcode = instr[IW-1:IW-6];
  assign target = instr[PCW-1:0];
  assign wa     = instr[RAW-1:0];
  assign ra2    = instr[2*RAW-1:RAW];
  assign ra1    = instr[3*RAW-1:2*RAW];
  assign imm    = instr[DW+RAW-1:RAW];

  logic [DW-1:0] rf [NR];
  logic [DW-1:0] rd1;
  logic [DW-1:0] rd2;

  assign rd1 = (ra1 == '0) ? '0 : rf[ra1];
  assign rd2 = (ra2 == '0) ? '0 : rf[ra2];

  logic [DW-1:0] res;
  logic          cy;
  logic [DW:0]   add_w;

  assign add_w = {1'b0, rd1} + {1'b0, rd2};

  always_comb begin
    res = '0;
    cy  = 1'b0;
    unique case (op_alu)
      3'b000: res = rd1;
      3'b001: res = ~rd1;
      3'b010: {cy, res} = add_w;
      3'b011: begin
        res = rd1 - rd2;
        cy  = (rd1 < rd2);
      end
      3'b100: res = rd1 & rd2;
      3'b101: res = rd1 | rd2;
      3'b110: res = '0 - rd1;
      3'b111: res = '0 - rd2;
      default: res = rd1;
    endcase
  end

  logic [DW-1:0] wd;
  assign wd = s_inm ? imm : res;

  // Stack array is padded to a power of two so stk_cnt indexes it directly
  logic [PCW-1:0] stk [NS];
  logic [PCW-1:0] pc_inc;
  logic [PCW-1:0] pc_n;
  logic [SW-1:0]  cnt_n;
  logic           push;
  logic           set_ovf;
  logic           set_unf;
  logic           full;
  logic           empty;

  assign pc_inc = pc + 1'b1;
  assign full   = (stk_cnt == SW'(SDEPTH));
  assign empty  = (stk_cnt == '0);

  always_comb begin
    pc_n    = pc_inc;
    cnt_n   = stk_cnt;
    push    = 1'b0;
    set_ovf = 1'b0;
    set_unf = 1'b0;
    if (ret) begin
      if (empty) begin
        set_unf = 1'b1;
      end else begin
        pc_n  = stk[stk_cnt - SW'(1)];
        cnt_n = stk_cnt - SW'(1);
      end
    end else if (call) begin
      pc_n = target;
      if (full) begin
        set_ovf = 1'b1;
      end else begin
        push  = 1'b1;
        cnt_n = stk_cnt + SW'(1);
      end
    end else if (!s_inc) begin
      pc_n = target;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc       <= '0;
      stk_cnt  <= '0;
      stk_ovf  <= 1'b0;
      stk_unf  <= 1'b0;
      z        <= 1'b0;
      c        <= 1'b0;
      out_data <= '0;
    end else begin
      pc      <= pc_n;
      stk_cnt <= cnt_n;
      if (set_ovf) stk_ovf <= 1'b1;
      if (set_unf) stk_unf <= 1'b1;
      if (wez) begin
        z <= (res == '0);
        c <= cy;
      end
      if (out_en) out_data <= rd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NR; i++) rf[i] <= '0;
    end else if (we3 && wa != '0) begin
      rf[wa] <= wd;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) stk[stk_cnt] <= pc_inc;
  end

endmodule
